// File: rtl/async_evt_arbiter.sv
// Synchronises N asynchronous request lines, detects edges, and serialises them onto one valid/ready port.
// Optional sticky overflow tracking is compiled in when AEA_OVF_EN is defined.
module async_evt_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int IDW         = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_async,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pend,
  output logic [N-1:0]   ovf,
  input  logic [N-1:0]   ovf_clr
);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [SYNC_STAGES-1:0] r_sync [N];
  logic [N-1:0]           r_hist;
  logic [N-1:0]           r_pend;
  logic [N-1:0]           w_cur;
  logic [N-1:0]           w_edge;
  logic [N-1:0]           w_clr;
  logic                   w_hs;

  state_t                 r_state, w_state_nxt;
  logic [IDW-1:0]         r_ptr, w_ptr_nxt;
  logic [IDW-1:0]         r_id, w_id_nxt;
  logic [IDW-1:0]         w_sel;
  logic                   w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      for (int i = 0; i < N; i++) r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], req_async[i]};
      r_hist <= w_cur;
    end
  end

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < N; i++) w_cur[i] = r_sync[i][SYNC_STAGES-1];
  end

  always_comb begin
    case (EDGE_MODE)
      0:       w_edge = w_cur & ~r_hist;
      1:       w_edge = ~w_cur & r_hist;
      default: w_edge = w_cur ^ r_hist;
    endcase
  end

  assign w_hs = (r_state == OFFER) && evt_ready;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N; i++) w_clr[i] = w_hs && (r_id == IDW'(i));
  end

  // An edge in the same cycle as its own handshake re-arms the flag instead of being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_clr) | w_edge;
  end

`ifdef AEA_OVF_EN
  logic [N-1:0] r_ovf;
  logic [N-1:0] w_ovf_set;

  assign w_ovf_set = w_edge & r_pend & ~w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= '0;
    else        r_ovf <= (r_ovf & ~ovf_clr) | w_ovf_set;
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ^ovf_clr;
  assign ovf              = '0;
`endif

  // Round-robin search: first pending channel at or after r_ptr, wrapping.
  always_comb begin
    int             k;
    logic [IDW-1:0] idx;
    w_found = 1'b0;
    w_sel   = '0;
    for (int j = 0; j < N; j++) begin
      k = int'(r_ptr) + j;
      if (k >= N) k = k - N;
      idx = IDW'(k);
      if (!w_found && r_pend[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OFFER;
          w_id_nxt    = w_sel;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = (r_id == IDW'(N-1)) ? '0 : r_id + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign evt_valid = (r_state == OFFER);
  assign evt_id    = r_id;
  assign pend      = r_pend;

endmodule

// File: tb/tb_async_evt_arbiter.sv
// Directed bench for async_evt_arbiter: a rising-edge instance and a both-edges instance.
module tb_async_evt_arbiter;

`ifdef AEA_OVF_EN
  localparam logic [3:0] EXP_OVF1 = 4'b0010;
`else
  localparam logic [3:0] EXP_OVF1 = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] req_a = '0, pend_a, ovf_a, ovfclr_a = '0;
  logic       ready_a = 1'b0, valid_a;
  logic [1:0] id_a;

  logic [3:0] req_b = '0, pend_b, ovf_b, ovfclr_b = '0;
  logic       ready_b = 1'b1, valid_b;
  logic [1:0] id_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  async_evt_arbiter #(.N(4), .SYNC_STAGES(2), .EDGE_MODE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_async(req_a), .evt_valid(valid_a), .evt_id(id_a),
    .evt_ready(ready_a), .pend(pend_a), .ovf(ovf_a), .ovf_clr(ovfclr_a)
  );

  async_evt_arbiter #(.N(4), .SYNC_STAGES(2), .EDGE_MODE(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_async(req_b), .evt_valid(valid_b), .evt_id(id_b),
    .evt_ready(ready_b), .pend(pend_b), .ovf(ovf_b), .ovf_clr(ovfclr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = '0; req_b = '0; ovfclr_a = '0; ovfclr_b = '0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid_a); end
    total++; if (id_a !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", id_a); end
    total++; if (pend_a !== 4'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0000", pend_a); end
    total++; if (ovf_a !== 4'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0000", ovf_a); end
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%0b exp=0", valid_b); end
  endtask

  task automatic test_single();
    do_reset();
    ready_a = 1'b1;
    req_a[2] = 1'b1;
    tick(); tick();
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", valid_a); end
    tick();
    total++; if (pend_a !== 4'b0100) begin bad++; $display("FAIL single_pend got=%b exp=0100", pend_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL single_k2 got=%0b exp=0", valid_a); end
    tick();
    total++; if (valid_a !== 1'b1 || id_a !== 2'd2) begin bad++; $display("FAIL single_offer got=%0b/%0d exp=1/2", valid_a, id_a); end
    tick();
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL single_len got=%0b exp=0", valid_a); end
    total++; if (pend_a !== 4'b0) begin bad++; $display("FAIL single_clr got=%b exp=0000", pend_a); end
    req_a[2] = 1'b0;
    repeat (4) tick();
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL single_fall got=%0b exp=0", valid_a); end
  endtask

  task automatic test_round_robin();
    logic       ev [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] ei [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
    do_reset();
    ready_a = 1'b1;
    req_a = 4'b1011;
    tick();
    req_a[0] = 1'b0;
    tick(); tick();
    req_a[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (valid_a !== ev[c] || (ev[c] && id_a !== ei[c])) begin
        bad++; $display("FAIL rr_seq c=%0d got=%0b/%0d exp=%0b/%0d", c + 3, valid_a, id_a, ev[c], ei[c]);
      end
    end
    total++; if (pend_a !== 4'b0) begin bad++; $display("FAIL rr_pend got=%b exp=0000", pend_a); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_a = 1'b0;
    req_a[1] = 1'b1;
    repeat (4) tick();
    total++; if (valid_a !== 1'b1 || id_a !== 2'd1) begin bad++; $display("FAIL bp_offer got=%0b/%0d exp=1/1", valid_a, id_a); end
    for (int s = 0; s < 10; s++) begin
      if (s == 1) req_a[0] = 1'b1;
      tick();
      total++;
      if (valid_a !== 1'b1 || id_a !== 2'd1) begin bad++; $display("FAIL bp_hold s=%0d got=%0b/%0d exp=1/1", s, valid_a, id_a); end
    end
    total++; if (pend_a !== 4'b0011) begin bad++; $display("FAIL bp_pend got=%b exp=0011", pend_a); end
    ready_a = 1'b1;
    tick();
    total++; if (valid_a !== 1'b0 || pend_a !== 4'b0001) begin bad++; $display("FAIL bp_hs got=%0b/%b exp=0/0001", valid_a, pend_a); end
    tick();
    total++; if (valid_a !== 1'b1 || id_a !== 2'd0) begin bad++; $display("FAIL bp_next got=%0b/%0d exp=1/0", valid_a, id_a); end
    tick();
    total++; if (valid_a !== 1'b0 || pend_a !== 4'b0) begin bad++; $display("FAIL bp_done got=%0b/%b exp=0/0000", valid_a, pend_a); end
  endtask

  task automatic test_overflow();
    int n_evt;
    do_reset();
    ready_a = 1'b0;
    req_a[1] = 1'b1;
    tick(); tick();
    req_a[1] = 1'b0;
    tick(); tick(); tick();
    req_a[1] = 1'b1;
    tick(); tick();
    total++; if (ovf_a !== 4'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0000", ovf_a); end
    tick(); tick();
    total++; if (ovf_a !== EXP_OVF1) begin bad++; $display("FAIL ovf_set got=%b exp=%b", ovf_a, EXP_OVF1); end
    total++; if (pend_a !== 4'b0010 || valid_a !== 1'b1 || id_a !== 2'd1) begin
      bad++; $display("FAIL ovf_offer got=%b/%0b/%0d exp=0010/1/1", pend_a, valid_a, id_a);
    end
    ready_a = 1'b1;
    tick();
    total++; if (valid_a !== 1'b0 || pend_a !== 4'b0) begin bad++; $display("FAIL ovf_hs got=%0b/%b exp=0/0000", valid_a, pend_a); end
    n_evt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (valid_a) n_evt++;
    end
    total++; if (n_evt !== 0) begin bad++; $display("FAIL ovf_single_evt got=%0d exp=0 extra", n_evt); end
    total++; if (ovf_a !== EXP_OVF1) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", ovf_a, EXP_OVF1); end
    ovfclr_a[1] = 1'b1;
    tick();
    ovfclr_a[1] = 1'b0;
    total++; if (ovf_a !== 4'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0000", ovf_a); end
  endtask

  task automatic test_edge_both();
    int n_evt;
    do_reset();
    req_b[0] = 1'b1;
    n_evt = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 4) req_b[0] = 1'b0;
      tick();
      if (valid_b) begin
        n_evt++;
        total++; if (id_b !== 2'd0) begin bad++; $display("FAIL both_id got=%0d exp=0", id_b); end
      end
    end
    total++; if (n_evt !== 2) begin bad++; $display("FAIL both_count got=%0d exp=2", n_evt); end
    total++; if (pend_b !== 4'b0) begin bad++; $display("FAIL both_pend got=%b exp=0000", pend_b); end

    do_reset();
    req_b[3] = 1'b1;
    tick(); tick();
    req_b[3] = 1'b0;
    tick(); tick();
    total++; if (valid_b !== 1'b1 || id_b !== 2'd3) begin bad++; $display("FAIL coin_offer got=%0b/%0d exp=1/3", valid_b, id_b); end
    tick();
    total++; if (pend_b !== 4'b1000 || ovf_b !== 4'b0 || valid_b !== 1'b0) begin
      bad++; $display("FAIL coin_keep got=%b/%b/%0b exp=1000/0000/0", pend_b, ovf_b, valid_b);
    end
    tick();
    total++; if (valid_b !== 1'b1 || id_b !== 2'd3) begin bad++; $display("FAIL coin_second got=%0b/%0d exp=1/3", valid_b, id_b); end
    tick();
    total++; if (valid_b !== 1'b0 || pend_b !== 4'b0) begin bad++; $display("FAIL coin_done got=%0b/%b exp=0/0000", valid_b, pend_b); end
  endtask

  task automatic test_mid_reset();
    int n_evt;
    do_reset();
    ready_a = 1'b0;
    req_a[2] = 1'b1;
    repeat (4) tick();
    total++; if (valid_a !== 1'b1 || pend_a !== 4'b0100) begin bad++; $display("FAIL mid_pre got=%0b/%b exp=1/0100", valid_a, pend_a); end
    #2;
    rst_n = 1'b0;
    req_a = '0;
    #1;
    total++; if (valid_a !== 1'b0 || id_a !== 2'd0) begin bad++; $display("FAIL mid_async got=%0b/%0d exp=0/0", valid_a, id_a); end
    total++; if (pend_a !== 4'b0 || ovf_a !== 4'b0) begin bad++; $display("FAIL mid_flags got=%b/%b exp=0000/0000", pend_a, ovf_a); end
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    ready_a = 1'b1;
    n_evt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid_a) n_evt++;
    end
    total++; if (n_evt !== 0) begin bad++; $display("FAIL mid_stale got=%0d exp=0", n_evt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_edge_both();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
